// File: rtl/voice_alloc_if.sv
`default_nettype none
// ============================================================================
//  Module      : voice_alloc_if
//  Description : Event and strobe bundle between the MIDI parser, the voice
//                allocator and the synth core slot table.
//                slave  : allocator side (takes events, drives strobes)
//                master : event source / strobe consumer side
//  Signals     : evt_valid/evt_ready handshake, evt_on, evt_panic,
//                evt_channel[3:0], evt_note[6:0], evt_velocity[6:0],
//                note_pressed, note_released, addr[7:0], note[6:0],
//                velocity[6:0], channel[3:0], busy_voices[7:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface voice_alloc_if;
    logic       evt_valid;
    logic       evt_ready;
    logic       evt_on;
    logic       evt_panic;
    logic [3:0] evt_channel;
    logic [6:0] evt_note;
    logic [6:0] evt_velocity;
    logic       note_pressed;
    logic       note_released;
    logic [7:0] addr;
    logic [6:0] note;
    logic [6:0] velocity;
    logic [3:0] channel;
    logic [7:0] busy_voices;

    modport slave (
        input  evt_valid, evt_on, evt_panic, evt_channel, evt_note, evt_velocity,
        output evt_ready, note_pressed, note_released, addr, note, velocity,
               channel, busy_voices
    );

    modport master (
        output evt_valid, evt_on, evt_panic, evt_channel, evt_note, evt_velocity,
        input  evt_ready, note_pressed, note_released, addr, note, velocity,
               channel, busy_voices
    );
endinterface
`default_nettype wire

// File: rtl/voice_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : voice_alloc
//  Description : Polyphonic voice allocator. Each accepted note-on/off event
//                triggers a one-slot-per-clock scan of the occupancy table,
//                then a single ISSUE cycle that emits the strobe and updates
//                the table. Oldest RELEASED voice is stolen before the oldest
//                ACTIVE one when no slot is free. Panic walks the table and
//                releases every ACTIVE slot.
//  Ports       : clk  - system clock
//                rst  - asynchronous reset, active low
//                bus  - voice_alloc_if.slave (event handshake, strobes,
//                       strobe fields, busy_voices count)
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_alloc #(
    parameter int NUM_VOICES = 128,
    parameter int STAMP_W    = 16
) (
    input  wire logic    clk,
    input  wire logic    rst,
    voice_alloc_if.slave bus
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_PANIC = 2'd3
    } fsm_t;

    typedef enum logic [1:0] {
        SLOT_FREE     = 2'd0,
        SLOT_ACTIVE   = 2'd1,
        SLOT_RELEASED = 2'd2
    } slot_t;

    // Occupancy table
    slot_t              slot_state_q [NUM_VOICES];
    slot_t              slot_state_d [NUM_VOICES];
    logic [3:0]         slot_chan_q  [NUM_VOICES];
    logic [3:0]         slot_chan_d  [NUM_VOICES];
    logic [6:0]         slot_note_q  [NUM_VOICES];
    logic [6:0]         slot_note_d  [NUM_VOICES];
    logic [STAMP_W-1:0] slot_stamp_q [NUM_VOICES];
    logic [STAMP_W-1:0] slot_stamp_d [NUM_VOICES];

    fsm_t               fsm_q, fsm_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [STAMP_W-1:0] stamp_cnt_q, stamp_cnt_d;
    logic [7:0]         busy_q, busy_d;

    // Latched event
    logic               ev_on_q, ev_on_d;
    logic [3:0]         ev_ch_q, ev_ch_d;
    logic [6:0]         ev_note_q, ev_note_d;
    logic [6:0]         ev_vel_q, ev_vel_d;

    // Scan candidates
    logic               match_vld_q, match_vld_d;
    logic [IDX_W-1:0]   match_idx_q, match_idx_d;
    logic               free_vld_q, free_vld_d;
    logic [IDX_W-1:0]   free_idx_q, free_idx_d;
    logic               rel_vld_q, rel_vld_d;
    logic [IDX_W-1:0]   rel_idx_q, rel_idx_d;
    logic [STAMP_W-1:0] rel_age_q, rel_age_d;
    logic               act_vld_q, act_vld_d;
    logic [IDX_W-1:0]   act_idx_q, act_idx_d;
    logic [STAMP_W-1:0] act_age_q, act_age_d;

    // Registered outputs
    logic               pressed_q, pressed_d;
    logic               released_q, released_d;
    logic [7:0]         addr_q, addr_d;
    logic [6:0]         note_q, note_d;
    logic [6:0]         vel_q, vel_d;
    logic [3:0]         chan_q, chan_d;

    logic [STAMP_W-1:0] scan_age;
    logic [IDX_W-1:0]   target;

    // Modular age: wrap of the stamp counter does not disturb ordering as
    // long as no voice lives for 2^STAMP_W allocations.
    always_comb begin
        scan_age = stamp_cnt_q - slot_stamp_q[idx_q];
    end

    // Note-on target priority. When nothing is free and nothing is released
    // every slot is ACTIVE, so the ACTIVE candidate is always valid there.
    always_comb begin
        target = act_idx_q;
        if (match_vld_q)      target = match_idx_q;
        else if (free_vld_q)  target = free_idx_q;
        else if (rel_vld_q)   target = rel_idx_q;
    end

    always_comb begin
        fsm_d        = fsm_q;
        idx_d        = idx_q;
        stamp_cnt_d  = stamp_cnt_q;
        busy_d       = busy_q;
        ev_on_d      = ev_on_q;
        ev_ch_d      = ev_ch_q;
        ev_note_d    = ev_note_q;
        ev_vel_d     = ev_vel_q;
        match_vld_d  = match_vld_q;
        match_idx_d  = match_idx_q;
        free_vld_d   = free_vld_q;
        free_idx_d   = free_idx_q;
        rel_vld_d    = rel_vld_q;
        rel_idx_d    = rel_idx_q;
        rel_age_d    = rel_age_q;
        act_vld_d    = act_vld_q;
        act_idx_d    = act_idx_q;
        act_age_d    = act_age_q;
        pressed_d    = 1'b0;
        released_d   = 1'b0;
        addr_d       = addr_q;
        note_d       = note_q;
        vel_d        = vel_q;
        chan_d       = chan_q;
        slot_state_d = slot_state_q;
        slot_chan_d  = slot_chan_q;
        slot_note_d  = slot_note_q;
        slot_stamp_d = slot_stamp_q;

        case (fsm_q)
            ST_IDLE: begin
                if (bus.evt_valid) begin
                    // Velocity 0 note-on is a note-off.
                    ev_on_d     = bus.evt_on && (bus.evt_velocity != 7'd0);
                    ev_ch_d     = bus.evt_channel;
                    ev_note_d   = bus.evt_note;
                    ev_vel_d    = bus.evt_velocity;
                    idx_d       = '0;
                    match_vld_d = 1'b0;
                    free_vld_d  = 1'b0;
                    rel_vld_d   = 1'b0;
                    act_vld_d   = 1'b0;
                    fsm_d       = bus.evt_panic ? ST_PANIC : ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (!match_vld_q && (slot_state_q[idx_q] != SLOT_FREE) &&
                    (slot_chan_q[idx_q] == ev_ch_q) && (slot_note_q[idx_q] == ev_note_q)) begin
                    match_vld_d = 1'b1;
                    match_idx_d = idx_q;
                end
                if (!free_vld_q && (slot_state_q[idx_q] == SLOT_FREE)) begin
                    free_vld_d = 1'b1;
                    free_idx_d = idx_q;
                end
                // Strict compare keeps the lowest index on equal age.
                if ((slot_state_q[idx_q] == SLOT_RELEASED) && (!rel_vld_q || (scan_age > rel_age_q))) begin
                    rel_vld_d = 1'b1;
                    rel_idx_d = idx_q;
                    rel_age_d = scan_age;
                end
                if ((slot_state_q[idx_q] == SLOT_ACTIVE) && (!act_vld_q || (scan_age > act_age_q))) begin
                    act_vld_d = 1'b1;
                    act_idx_d = idx_q;
                    act_age_d = scan_age;
                end
                if (idx_q == C_LAST_IDX) fsm_d = ST_ISSUE;
                else                     idx_d = idx_q + IDX_W'(1);
            end

            ST_ISSUE: begin
                if (ev_on_q) begin
                    pressed_d            = 1'b1;
                    addr_d               = 8'(target);
                    note_d               = ev_note_q;
                    vel_d                = ev_vel_q;
                    chan_d               = ev_ch_q;
                    if (slot_state_q[target] != SLOT_ACTIVE) busy_d = busy_q + 8'd1;
                    slot_state_d[target] = SLOT_ACTIVE;
                    slot_chan_d[target]  = ev_ch_q;
                    slot_note_d[target]  = ev_note_q;
                    slot_stamp_d[target] = stamp_cnt_q;
                    stamp_cnt_d          = stamp_cnt_q + STAMP_W'(1);
                end else if (match_vld_q && (slot_state_q[match_idx_q] == SLOT_ACTIVE)) begin
                    released_d                = 1'b1;
                    addr_d                    = 8'(match_idx_q);
                    note_d                    = ev_note_q;
                    vel_d                     = ev_vel_q;
                    chan_d                    = ev_ch_q;
                    busy_d                    = busy_q - 8'd1;
                    slot_state_d[match_idx_q] = SLOT_RELEASED;
                end
                fsm_d = ST_IDLE;
            end

            ST_PANIC: begin
                if (slot_state_q[idx_q] == SLOT_ACTIVE) begin
                    released_d          = 1'b1;
                    addr_d              = 8'(idx_q);
                    note_d              = slot_note_q[idx_q];
                    vel_d               = 7'd0;
                    chan_d              = slot_chan_q[idx_q];
                    busy_d              = busy_q - 8'd1;
                    slot_state_d[idx_q] = SLOT_RELEASED;
                end
                if (idx_q == C_LAST_IDX) fsm_d = ST_IDLE;
                else                     idx_d = idx_q + IDX_W'(1);
            end

            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q       <= ST_IDLE;
            idx_q       <= '0;
            stamp_cnt_q <= '0;
            busy_q      <= '0;
            ev_on_q     <= 1'b0;
            ev_ch_q     <= '0;
            ev_note_q   <= '0;
            ev_vel_q    <= '0;
            match_vld_q <= 1'b0;
            match_idx_q <= '0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
            rel_vld_q   <= 1'b0;
            rel_idx_q   <= '0;
            rel_age_q   <= '0;
            act_vld_q   <= 1'b0;
            act_idx_q   <= '0;
            act_age_q   <= '0;
            pressed_q   <= 1'b0;
            released_q  <= 1'b0;
            addr_q      <= '0;
            note_q      <= '0;
            vel_q       <= '0;
            chan_q      <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                slot_state_q[i] <= SLOT_FREE;
                slot_chan_q[i]  <= '0;
                slot_note_q[i]  <= '0;
                slot_stamp_q[i] <= '0;
            end
        end else begin
            fsm_q        <= fsm_d;
            idx_q        <= idx_d;
            stamp_cnt_q  <= stamp_cnt_d;
            busy_q       <= busy_d;
            ev_on_q      <= ev_on_d;
            ev_ch_q      <= ev_ch_d;
            ev_note_q    <= ev_note_d;
            ev_vel_q     <= ev_vel_d;
            match_vld_q  <= match_vld_d;
            match_idx_q  <= match_idx_d;
            free_vld_q   <= free_vld_d;
            free_idx_q   <= free_idx_d;
            rel_vld_q    <= rel_vld_d;
            rel_idx_q    <= rel_idx_d;
            rel_age_q    <= rel_age_d;
            act_vld_q    <= act_vld_d;
            act_idx_q    <= act_idx_d;
            act_age_q    <= act_age_d;
            pressed_q    <= pressed_d;
            released_q   <= released_d;
            addr_q       <= addr_d;
            note_q       <= note_d;
            vel_q        <= vel_d;
            chan_q       <= chan_d;
            slot_state_q <= slot_state_d;
            slot_chan_q  <= slot_chan_d;
            slot_note_q  <= slot_note_d;
            slot_stamp_q <= slot_stamp_d;
        end
    end

    assign bus.evt_ready     = (fsm_q == ST_IDLE);
    assign bus.note_pressed  = pressed_q;
    assign bus.note_released = released_q;
    assign bus.addr          = addr_q;
    assign bus.note          = note_q;
    assign bus.velocity      = vel_q;
    assign bus.channel       = chan_q;
    assign bus.busy_voices   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_voice_alloc
//  Description : Self-checking bench for voice_alloc. Directed steps push the
//                expected strobes to a queue; a monitor pops and compares
//                every strobe the allocator emits.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_alloc;

    localparam int NV = 128;

    typedef struct {
        bit is_press;
        int addr;
        int note;
        int chan;
        int vel;
        bit chk_vel;
        int lat_lo;
        int lat_hi;
    } strobe_t;

    logic clk;
    logic rst;
    int   cyc;
    int   acc_cyc;
    int   n_cmp;
    int   n_fail;
    int   low_cnt;
    strobe_t exp_q[$];

    voice_alloc_if bus ();

    voice_alloc #(.NUM_VOICES(NV), .STAMP_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, req);
        end
    endtask

    task automatic expect_strobe(input bit p, input int a, input int n, input int c,
                                 input int v, input bit cv, input int lo, input int hi);
        strobe_t e;
        e.is_press = p; e.addr = a; e.note = n; e.chan = c;
        e.vel = v; e.chk_vel = cv; e.lat_lo = lo; e.lat_hi = hi;
        exp_q.push_back(e);
    endtask

    // Note-on/off strobes land exactly NV+1 cycles after acceptance.
    task automatic expect_press(input int a, input int n, input int c, input int v);
        expect_strobe(1'b1, a, n, c, v, 1'b1, NV + 1, NV + 1);
    endtask

    task automatic expect_release(input int a, input int n, input int c, input int v);
        expect_strobe(1'b0, a, n, c, v, 1'b1, NV + 1, NV + 1);
    endtask

    // Drives one event, scrambles the inputs after acceptance, waits for the
    // allocator to return to IDLE and checks that every expected strobe came.
    task automatic send(input bit on, input bit pnc, input logic [3:0] ch,
                        input logic [6:0] n, input logic [6:0] v, output int low);
        @(negedge clk);
        bus.evt_valid    = 1'b1;
        bus.evt_on       = on;
        bus.evt_panic    = pnc;
        bus.evt_channel  = ch;
        bus.evt_note     = n;
        bus.evt_velocity = v;
        @(posedge clk);
        #1;
        acc_cyc          = cyc;
        bus.evt_valid    = 1'b0;
        bus.evt_on       = ~on;
        bus.evt_panic    = 1'b0;
        bus.evt_channel  = ~ch;
        bus.evt_note     = ~n;
        bus.evt_velocity = ~v;
        low = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.evt_ready) break;
            low++;
        end
        chk("evt_ready_return", {31'd0, bus.evt_ready}, 32'd1);
        @(negedge clk);
        chk("strobes_outstanding", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Strobe monitor
    initial begin
        strobe_t e;
        int lat;
        forever begin
            @(negedge clk);
            if (rst && (bus.note_pressed || bus.note_released)) begin
                chk("strobe_exclusive", {31'd0, bus.note_pressed & bus.note_released}, 32'd0);
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_strobe: observed press=%0d release=%0d addr=%0d required none",
                           bus.note_pressed, bus.note_released, bus.addr);
                end
                if (exp_q.size() != 0) begin
                    e   = exp_q.pop_front();
                    lat = cyc - acc_cyc;
                    chk("strobe_kind_press", {31'd0, bus.note_pressed}, {31'd0, e.is_press});
                    chk("strobe_addr", {24'd0, bus.addr}, e.addr);
                    chk("strobe_note", {25'd0, bus.note}, e.note);
                    chk("strobe_channel", {28'd0, bus.channel}, e.chan);
                    if (e.chk_vel) chk("strobe_velocity", {25'd0, bus.velocity}, e.vel);
                    if (e.lat_lo == e.lat_hi) chk("strobe_latency", lat, e.lat_lo);
                    else chk("strobe_latency_window", {31'd0, (lat >= e.lat_lo) && (lat <= e.lat_hi)}, 32'd1);
                end
            end
        end
    end

    initial begin
        cyc              = 0;
        acc_cyc          = 0;
        n_cmp            = 0;
        n_fail           = 0;
        rst              = 1'b0;
        bus.evt_valid    = 1'b0;
        bus.evt_on       = 1'b0;
        bus.evt_panic    = 1'b0;
        bus.evt_channel  = 4'd0;
        bus.evt_note     = 7'd0;
        bus.evt_velocity = 7'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_evt_ready", {31'd0, bus.evt_ready}, 32'd1);
        chk("rst_pressed", {31'd0, bus.note_pressed}, 32'd0);
        chk("rst_released", {31'd0, bus.note_released}, 32'd0);
        chk("rst_addr", {24'd0, bus.addr}, 32'd0);
        chk("rst_note", {25'd0, bus.note}, 32'd0);
        chk("rst_velocity", {25'd0, bus.velocity}, 32'd0);
        chk("rst_channel", {28'd0, bus.channel}, 32'd0);
        chk("rst_busy", {24'd0, bus.busy_voices}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // First note-on: slot 0, ready low for NV+1 sampled cycles
        expect_press(0, 60, 0, 100);
        send(1'b1, 1'b0, 4'd0, 7'd60, 7'd100, low_cnt);
        chk("ready_low_cycles", low_cnt, NV + 1);
        chk("busy_after_first_on", {24'd0, bus.busy_voices}, 32'd1);

        // Different channel, same note -> next free slot
        expect_press(1, 60, 1, 90);
        send(1'b1, 1'b0, 4'd1, 7'd60, 7'd90, low_cnt);
        chk("busy_two_on", {24'd0, bus.busy_voices}, 32'd2);

        // Note-off ch0 n60 -> release slot 0
        expect_release(0, 60, 0, 40);
        send(1'b0, 1'b0, 4'd0, 7'd60, 7'd40, low_cnt);
        chk("busy_after_off", {24'd0, bus.busy_voices}, 32'd1);

        // Slot 0 is RELEASED, slot 1 ACTIVE -> first FREE is slot 2
        expect_press(2, 64, 2, 80);
        send(1'b1, 1'b0, 4'd2, 7'd64, 7'd80, low_cnt);
        chk("busy_ch2_on", {24'd0, bus.busy_voices}, 32'd2);

        // Retrigger in place, no release, busy unchanged
        expect_press(2, 64, 2, 70);
        send(1'b1, 1'b0, 4'd2, 7'd64, 7'd70, low_cnt);
        chk("busy_retrigger", {24'd0, bus.busy_voices}, 32'd2);

        // Velocity-0 note-on behaves as note-off
        expect_release(2, 64, 2, 0);
        send(1'b1, 1'b0, 4'd2, 7'd64, 7'd0, low_cnt);
        chk("busy_vel0_off", {24'd0, bus.busy_voices}, 32'd1);

        // Two more voices: slots 3 and 4 (0 and 2 are RELEASED)
        expect_press(3, 10, 3, 50);
        send(1'b1, 1'b0, 4'd3, 7'd10, 7'd50, low_cnt);
        expect_press(4, 11, 3, 51);
        send(1'b1, 1'b0, 4'd3, 7'd11, 7'd51, low_cnt);
        chk("busy_three_active", {24'd0, bus.busy_voices}, 32'd3);

        // Panic: releases ACTIVE slots 1, 3, 4 only
        expect_strobe(1'b0, 1, 60, 1, 0, 1'b0, 1, NV);
        expect_strobe(1'b0, 3, 10, 3, 0, 1'b0, 1, NV);
        expect_strobe(1'b0, 4, 11, 3, 0, 1'b0, 1, NV);
        send(1'b0, 1'b1, 4'd0, 7'd0, 7'd0, low_cnt);
        chk("panic_cycles", low_cnt, NV);
        chk("busy_after_panic", {24'd0, bus.busy_voices}, 32'd0);

        // Note-off for unknown note and for an already released note: no strobe
        send(1'b0, 1'b0, 4'd5, 7'd99, 7'd10, low_cnt);
        send(1'b0, 1'b0, 4'd1, 7'd60, 7'd10, low_cnt);
        chk("busy_after_unknown_off", {24'd0, bus.busy_voices}, 32'd0);

        // Fill every slot, free slot 0 by note-off, reuse it, then steal
        do_reset();
        for (int i = 0; i < NV; i++) begin
            expect_press(i, i, 0, (i % 100) + 1);
            send(1'b1, 1'b0, 4'd0, 7'(i), 7'((i % 100) + 1), low_cnt);
        end
        chk("busy_full", {24'd0, bus.busy_voices}, NV);
        expect_release(0, 0, 0, 20);
        send(1'b0, 1'b0, 4'd0, 7'd0, 7'd20, low_cnt);
        chk("busy_full_minus_one", {24'd0, bus.busy_voices}, NV - 1);
        expect_press(0, 100, 1, 33);
        send(1'b1, 1'b0, 4'd1, 7'd100, 7'd33, low_cnt);
        chk("busy_reuse_released", {24'd0, bus.busy_voices}, NV);
        expect_press(1, 101, 1, 34);
        send(1'b1, 1'b0, 4'd1, 7'd101, 7'd34, low_cnt);
        chk("busy_after_steal", {24'd0, bus.busy_voices}, NV);

        // Stamp counter wraps during the fill; oldest is still slot 0
        do_reset();
        @(negedge clk);
        force dut.stamp_cnt_q = 16'hFFC0;
        @(negedge clk);
        release dut.stamp_cnt_q;
        for (int i = 0; i < NV; i++) begin
            expect_press(i, i, 0, 5);
            send(1'b1, 1'b0, 4'd0, 7'(i), 7'd5, low_cnt);
        end
        expect_press(0, 5, 1, 9);
        send(1'b1, 1'b0, 4'd1, 7'd5, 7'd9, low_cnt);
        expect_press(1, 6, 1, 9);
        send(1'b1, 1'b0, 4'd1, 7'd6, 7'd9, low_cnt);

        // Reset in the middle of a scan: event abandoned, table cleared
        @(negedge clk);
        bus.evt_valid    = 1'b1;
        bus.evt_on       = 1'b1;
        bus.evt_panic    = 1'b0;
        bus.evt_channel  = 4'd0;
        bus.evt_note     = 7'd1;
        bus.evt_velocity = 7'd64;
        @(posedge clk);
        #1;
        bus.evt_valid = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midscan_rst_ready", {31'd0, bus.evt_ready}, 32'd1);
        chk("midscan_rst_busy", {24'd0, bus.busy_voices}, 32'd0);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        chk("midscan_no_strobe", exp_q.size(), 32'd0);
        expect_press(0, 20, 4, 44);
        send(1'b1, 1'b0, 4'd4, 7'd20, 7'd44, low_cnt);
        chk("busy_after_midscan", {24'd0, bus.busy_voices}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
